refclk_tick_gen: RTL and testbench

REFCLK_TICK_GEN -- requirements
Module: refclk_tick_gen

---
 rtl/refclk_tick_gen_pkg.sv | 31 +++
 rtl/refclk_tick_gen_if.sv | 24 ++
 rtl/refclk_tick_gen_phase_accum.sv | 29 ++
 rtl/refclk_tick_gen.sv | 117 +++++++++++
 tb/tb_refclk_tick_gen.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/refclk_tick_gen_pkg.sv
// Shared clock-block helpers: rate-select encoding, clog2 and phase increment.
package refclk_tick_gen_pkg;

  typedef enum logic [1:0] {
    RATE_SEL_0 = 2'd0,
    RATE_SEL_1 = 2'd1,
    RATE_SEL_2 = 2'd2,
    RATE_SEL_3 = 2'd3
  } rate_sel_e;

  localparam int NUM_RATES = 4;

  function automatic int clog2(input longint n);
    int w;
    w = 0;
    for (int i = 0; i < 62; i++)
      if ((longint'(1) << i) < n) w = i + 1;
    return w;
  endfunction

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input longint n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic longint phase_inc(input int acc_w, input longint rate_hz,
                                       input longint ref_hz);
    return ((longint'(1) << acc_w) * rate_hz) / ref_hz;
  endfunction

endpackage

// File: rtl/refclk_tick_gen_if.sv
// Control/strobe bundle of the reference-clock tick generator.
interface refclk_tick_gen_if;
  import refclk_tick_gen_pkg::*;

  logic      i_en;
  logic      i_refclk;
  rate_sel_e i_rate_sel;
  logic      i_sync_clear;
  logic      o_ref_tick;
  logic      o_tick_1hz;
  logic      o_set_tick;
  logic      o_refclk_lost;

  modport master (
    output i_en, i_refclk, i_rate_sel, i_sync_clear,
    input  o_ref_tick, o_tick_1hz, o_set_tick, o_refclk_lost
  );

  modport slave (
    input  i_en, i_refclk, i_rate_sel, i_sync_clear,
    output o_ref_tick, o_tick_1hz, o_set_tick, o_refclk_lost
  );

endinterface

// File: rtl/refclk_tick_gen_phase_accum.sv
// Modulo-2^ACC_W phase accumulator; carry strobes when a step wraps it.
module phase_accum #(
  parameter int ACC_W = 30
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             step,
  input  logic [ACC_W-1:0] inc,
  output logic             carry
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, acc_q} + {1'b0, inc};
  // A clearing cycle drops both the add and its carry.
  assign carry = en & step & ~clr & sum[ACC_W];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)   acc_q <= '0;
    else if (en) begin
      if (clr)        acc_q <= '0;
      else if (step)  acc_q <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/refclk_tick_gen.sv
// Reference-clock tick generator: sync + edge detect, 1 Hz divider, rate
// strobe via phase accumulator, and loss watchdog with substitute ticks.
module refclk_tick_gen
  import refclk_tick_gen_pkg::*;
#(
  parameter int REF_CLK_HZ   = 32768,
  parameter int SYNC_STAGES  = 2,
  parameter int RATE0_HZ     = 1,
  parameter int RATE1_HZ     = 2,
  parameter int RATE2_HZ     = 5,
  parameter int RATE3_HZ     = 10,
  parameter int ACC_W        = 30,
  parameter int LOSS_CYCLES  = 4096,
  parameter int FALLBACK_DIV = 305
) (
  input logic         i_clk,
  input logic         i_reset_n,
  refclk_tick_gen_if.slave bus
);

  localparam int CNT_W = cnt_w(REF_CLK_HZ);
  localparam int WD_W  = cnt_w(LOSS_CYCLES + 1);
  localparam int FB_W  = cnt_w(FALLBACK_DIV);

  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(REF_CLK_HZ - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(LOSS_CYCLES);
  localparam logic [FB_W-1:0]  FB_LAST  = FB_W'(FALLBACK_DIV - 1);

  localparam logic [NUM_RATES-1:0][ACC_W-1:0] INC = {
    ACC_W'(phase_inc(ACC_W, RATE3_HZ, REF_CLK_HZ)),
    ACC_W'(phase_inc(ACC_W, RATE2_HZ, REF_CLK_HZ)),
    ACC_W'(phase_inc(ACC_W, RATE1_HZ, REF_CLK_HZ)),
    ACC_W'(phase_inc(ACC_W, RATE0_HZ, REF_CLK_HZ))
  };

  logic                   en, act;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   real_tick, sub_tick, ref_tick;
  logic [WD_W-1:0]        wd_cnt;
  logic [FB_W-1:0]        fb_cnt;
  logic                   lost_q;
  logic [CNT_W-1:0]       sec_cnt;
  logic                   clr, tick_1hz;
  rate_sel_e              rate_q;
  logic                   rate_chg, set_tick;

  assign en  = bus.i_en;
  // Strobes are also masked in the reset cycle so nothing escapes from stale state.
  assign act = en & i_reset_n;
  assign clr = bus.i_sync_clear;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else if (en) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_refclk};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign real_tick = act & sync_q[SYNC_STAGES-1] & ~dly_q;
  assign sub_tick  = act & lost_q & ~real_tick & (fb_cnt == FB_LAST);
  assign ref_tick  = real_tick | sub_tick;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wd_cnt <= '0;
      fb_cnt <= '0;
      lost_q <= 1'b0;
    end else if (en) begin
      if (real_tick) begin
        wd_cnt <= '0;
        fb_cnt <= '0;
        lost_q <= 1'b0;
      end else begin
        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_W'(1);
        else                  lost_q <= 1'b1;
        if (lost_q) fb_cnt <= (fb_cnt == FB_LAST) ? '0 : fb_cnt + FB_W'(1);
      end
    end
  end

  assign tick_1hz = ref_tick & ~clr & (sec_cnt == SEC_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)    sec_cnt <= '0;
    else if (en) begin
      if (clr)           sec_cnt <= '0;
      else if (ref_tick) sec_cnt <= (sec_cnt == SEC_LAST) ? '0 : sec_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) rate_q <= RATE_SEL_0;
    else if (en)    rate_q <= bus.i_rate_sel;
  end

  assign rate_chg = (bus.i_rate_sel != rate_q);

  phase_accum #(.ACC_W(ACC_W)) u_accum (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .en        (en),
    .clr       (clr | rate_chg),
    .step      (ref_tick),
    .inc       (INC[bus.i_rate_sel]),
    .carry     (set_tick)
  );

  assign bus.o_ref_tick    = ref_tick;
  assign bus.o_tick_1hz    = tick_1hz;
  assign bus.o_set_tick    = set_tick;
  assign bus.o_refclk_lost = lost_q;

endmodule

// File: tb/tb_refclk_tick_gen.sv
// Randomised bench: behavioural model predicts each cycle's outputs into a
// queue; an independent monitor pops and compares against the DUT.
module tb_refclk_tick_gen;
  import refclk_tick_gen_pkg::*;

  localparam int HZ = 8, S = 2, AW = 4, LOSS = 20, FB = 5;
  localparam int R0 = 1, R1 = 2, R2 = 2, R3 = 4;

  typedef struct packed {
    logic rtk;
    logic hz;
    logic set;
    logic lost;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  refclk_tick_gen_if bus();

  refclk_tick_gen #(
    .REF_CLK_HZ(HZ), .SYNC_STAGES(S),
    .RATE0_HZ(R0), .RATE1_HZ(R1), .RATE2_HZ(R2), .RATE3_HZ(R3),
    .ACC_W(AW), .LOSS_CYCLES(LOSS), .FALLBACK_DIV(FB)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  exp_t expq[$];
  int   n_chk = 0, n_pass = 0;
  int   n_wrapclr = 0, n_sub = 0, n_set = 0, n_hz = 0;

  // Model state: refclk samples at enabled edges, enabled cycles since the
  // last real tick, ref ticks within the current second, phase value.
  bit   hist[$];
  int   e = 0, n1 = 0, acc = 0, psel = 0;
  int   rate_hz[4];
  bit   rc = 1'b0;
  int   cur_sel = 2;

  function automatic bit smp(input int k);
    if (k >= hist.size()) return 1'b0;
    return hist[hist.size() - 1 - k];
  endfunction

  task automatic cycle(input bit en, input bit clr, input bit rn, input bit wrapclr);
    exp_t x;
    bit   act, rl, lost, sb, rt, chg;
    int   inc;
    act  = en && rn;
    rl   = act && smp(S - 1) && !smp(S);
    lost = e > LOSS;
    sb   = act && lost && !rl && ((e - LOSS - 1) % FB == FB - 1);
    rt   = rl || sb;
    if (wrapclr && rt && n1 == HZ - 1) begin clr = 1'b1; n_wrapclr++; end
    chg  = cur_sel != psel;
    inc  = (rate_hz[cur_sel] << AW) / HZ;
    bus.i_en         = en;
    bus.i_refclk     = rc;
    bus.i_rate_sel   = rate_sel_e'(2'(cur_sel));
    bus.i_sync_clear = clr;
    rst_n            = rn;
    x.rtk  = rt;
    x.hz   = rt && !clr && n1 == HZ - 1;
    x.set  = rt && !clr && !chg && (acc + inc >= (1 << AW));
    x.lost = lost;
    if (sb) n_sub++;
    if (x.set) n_set++;
    if (x.hz) n_hz++;
    expq.push_back(x);
    @(posedge clk);
    if (!rn) begin
      hist.delete();
      e = 0; n1 = 0; acc = 0; psel = 0;
    end else if (en) begin
      hist.push_back(rc);
      if (hist.size() > S + 1) void'(hist.pop_front());
      e = rl ? 0 : e + 1;
      if (clr)     n1 = 0;
      else if (rt) n1 = (n1 + 1) % HZ;
      if (clr || chg) acc = 0;
      else if (rt)    acc = (acc + inc) % (1 << AW);
      psel = cur_sel;
    end
    @(negedge clk);
  endtask

  // Toggle the reference with random half periods, sprinkling enable drops,
  // rate changes and sync clears at the given percentages.
  task automatic run_ref(input int nper, input int p_en, input int p_sel,
                         input int p_clr, input bit wrapclr);
    int half;
    for (int p = 0; p < nper; p++) begin
      half = $urandom_range(1, 4);
      for (int c = 0; c < half; c++) begin
        if ($urandom_range(0, 99) < p_sel) cur_sel = $urandom_range(0, 3);
        cycle($urandom_range(0, 99) >= p_en, $urandom_range(0, 99) < p_clr, 1'b1, wrapclr);
      end
      rc = ~rc;
      if (wrapclr && n_wrapclr > 0) break;
    end
  endtask

  initial begin : monitor
    exp_t x, got;
    forever begin
      @(negedge clk);
      #3;
      if (expq.size() > 0) begin
        x   = expq.pop_front();
        got = {bus.o_ref_tick, bus.o_tick_1hz, bus.o_set_tick, bus.o_refclk_lost};
        n_chk++;
        if (got === x) n_pass++;
        else $display("FAIL strobes t=%0t got ref/1hz/set/lost=%b%b%b%b exp=%b%b%b%b",
                      $time, got.rtk, got.hz, got.set, got.lost,
                      x.rtk, x.hz, x.set, x.lost);
      end
    end
  end

  initial begin : stim
    rate_hz = '{R0, R1, R2, R3};
    bus.i_en = 1'b0; bus.i_refclk = 1'b0; bus.i_sync_clear = 1'b0;
    bus.i_rate_sel = RATE_SEL_2;
    @(negedge clk);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // Clean stream at fixed rate 2: 1 Hz and every-4th-tick set strobes.
    run_ref(40, 0, 0, 0, 1'b0);
    // Mixed disturbances: enable drops, rate changes, sync clears.
    run_ref(120, 8, 4, 3, 1'b0);
    // Sync clear landing exactly on the wrapping tick.
    cur_sel = 1;
    run_ref(80, 0, 0, 0, 1'b1);
    run_ref(12, 0, 0, 0, 1'b0);
    // Reference stops: loss, substitute ticks, then recovery.
    repeat (3) begin
      repeat ($urandom_range(30, 50)) cycle(1'b1, 1'b0, 1'b1, 1'b0);
      run_ref(6, 0, 0, 0, 1'b0);
    end
    // Freeze mid-count, then reset mid-count.
    run_ref(5, 0, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) rc = ~rc;
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
    end
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_ref(20, 0, 0, 0, 1'b0);
    #5;
    n_chk++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL drain leftover=%0d required=0", expq.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
